// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_sequencer
// Description : Steps the x/y selects of a 4:1 mux through the enabled
//               channels, waits a programmable dwell, samples f_in and
//               hands each sample off over valid/ready.
//               Optional continuous mode: MUX_SCAN_CONT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               f_in,
    output logic               x,
    output logic               y,
    output logic               smp_data,
    output logic [1:0]         smp_ch,
    output logic               smp_valid,
    input  logic               smp_ready,
    output logic               busy,
    output logic               done
);

    localparam logic [DWELL_W-1:0] c_CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_mask, w_mask_nxt;
    logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
    logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]         r_ch, w_ch_nxt;
    logic               r_smp_data, w_smp_data_nxt;
    logic [1:0]         r_smp_ch, w_smp_ch_nxt;
    logic               r_smp_valid, w_smp_valid_nxt;
    logic               r_busy, r_done, w_done_nxt;
    logic [3:0]         w_above;
    logic               w_wrap;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Enabled channels strictly above the current one.
    assign w_above = r_mask & (4'b1110 << r_ch);

`ifdef MUX_SCAN_CONT_EN
    assign w_wrap = start;
`else
    assign w_wrap = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_mask_nxt      = r_mask;
        w_dwell_nxt     = r_dwell;
        w_cnt_nxt       = r_cnt;
        w_ch_nxt        = r_ch;
        w_smp_data_nxt  = r_smp_data;
        w_smp_ch_nxt    = r_smp_ch;
        w_smp_valid_nxt = r_smp_valid;
        w_done_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (ch_mask != 4'd0)) begin
                    w_mask_nxt  = ch_mask;
                    w_dwell_nxt = dwell;
                    w_ch_nxt    = lowest(ch_mask);
                    w_cnt_nxt   = dwell;
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end else begin
                    w_smp_data_nxt  = f_in;
                    w_smp_ch_nxt    = r_ch;
                    w_smp_valid_nxt = 1'b1;
                    w_state_nxt     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (smp_ready) begin
                    w_smp_valid_nxt = 1'b0;
                    if (w_above != 4'd0) begin
                        w_ch_nxt    = lowest(w_above);
                        w_cnt_nxt   = r_dwell;
                        w_state_nxt = S_SETTLE;
                    end else begin
                        w_done_nxt = 1'b1;
                        if (w_wrap) begin
                            w_ch_nxt    = lowest(r_mask);
                            w_cnt_nxt   = r_dwell;
                            w_state_nxt = S_SETTLE;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mask      <= 4'd0;
            r_dwell     <= '0;
            r_cnt       <= '0;
            r_ch        <= 2'd0;
            r_smp_data  <= 1'b0;
            r_smp_ch    <= 2'd0;
            r_smp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mask      <= w_mask_nxt;
            r_dwell     <= w_dwell_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ch        <= w_ch_nxt;
            r_smp_data  <= w_smp_data_nxt;
            r_smp_ch    <= w_smp_ch_nxt;
            r_smp_valid <= w_smp_valid_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= w_done_nxt;
        end
    end

    assign x         = r_ch[0];
    assign y         = r_ch[1];
    assign smp_data  = r_smp_data;
    assign smp_ch    = r_smp_ch;
    assign smp_valid = r_smp_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
